// File: rtl/axis_adc_avg_pkg.sv
// Shared types, widths and helpers for the AXI-Stream ADC boxcar averager.
// AXIS_ADC_AVG_ROUND_EN widens the accumulator by one guard bit for round-half-up.
package adc_avg_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} avg_state_t;

    localparam int DATA_WIDTH   = 32;
    localparam int SAMPLE_WIDTH = 24;
    localparam int MAX_LOG2_AVG = 8;
`ifdef AXIS_ADC_AVG_ROUND_EN
    localparam int ACC_GUARD    = 1;
`else
    localparam int ACC_GUARD    = 0;
`endif
    localparam int ACC_WIDTH    = SAMPLE_WIDTH + MAX_LOG2_AVG + ACC_GUARD;

    function automatic logic [3:0] clamp_log2(input logic [3:0] log2_val, input int max_log2);
        return (int'(log2_val) > max_log2) ? 4'(max_log2) : log2_val;
    endfunction

endpackage

// File: rtl/axis_adc_avg_if.sv
// AXI-Stream bundle shared by the averager's input and output sides.
interface axis_adc_avg_if #(parameter int DW = 32);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_adc_avg_framer.sv
// Packet framer: counts output beats and flags the beat that closes each packet.
module axis_adc_avg_framer (
    input  logic        aclk,
    input  logic        areset,
    input  logic        en,
    input  logic        beat,
    input  logic [15:0] packet_len,
    output logic        tlast
);
    logic [15:0] cnt_reg;
    logic [15:0] len_reg;
    logic [15:0] len_eff;
    logic [15:0] cnt_next;

    // tlast is evaluated for the beat about to be loaded, so it travels with its data.
    always_comb begin
        len_eff  = (cnt_reg == '0) ? packet_len : len_reg;
        cnt_next = cnt_reg + 16'd1;
        tlast    = (len_eff != '0) && (cnt_next == len_eff);
    end

    always_ff @(posedge aclk) begin
        if (areset || !en) begin
            cnt_reg <= '0;
            len_reg <= '0;
        end else if (beat) begin
            if (cnt_reg == '0) begin
                len_reg <= packet_len;
            end
            // A zero length keeps the counter parked so a new length applies at once.
            cnt_reg <= (tlast || len_eff == '0) ? '0 : cnt_next;
        end
    end
endmodule

// File: rtl/axis_adc_avg.sv
// Boxcar averager of 2^log2_avg signed ADC samples with packet framing on the output.
// Define AXIS_ADC_AVG_ROUND_EN for round-half-up results; default is floor.
module axis_adc_avg
    import adc_avg_pkg::*;
(
    input  logic            aclk,
    input  logic            areset,
    input  logic            en,
    input  logic [3:0]      log2_avg,
    input  logic [15:0]     packet_len,
    axis_adc_avg_if.slave   s_axis,
    axis_adc_avg_if.master  m_axis
);
    localparam int CW = MAX_LOG2_AVG + 1;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    avg_state_t              state_reg, state_next;
    acc_t                    acc_reg, acc_next;
    logic [CW-1:0]           count_reg, count_next;
    logic [3:0]              n_reg, n_next;
    logic [SAMPLE_WIDTH-1:0] hold_reg, hold_next;
    logic                    s_ready_reg;
    logic [DATA_WIDTH-1:0]   tdata_reg;
    logic                    tvalid_reg;
    logic                    tlast_reg;

    logic                    sample_hs;
    logic                    out_free;
    logic                    out_load;
    logic                    frame_last;
    logic [3:0]              n_eff;
    logic [CW-1:0]           win_max;
    acc_t                    sample_ext;
    acc_t                    sum;
    acc_t                    result_pre;
    logic signed [SAMPLE_WIDTH-1:0] avg;
    logic [SAMPLE_WIDTH-1:0] load_sample;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    unused_bits;

    assign unused_bits = ^{s_axis.tlast, s_axis.tdata[DATA_WIDTH-1:SAMPLE_WIDTH]};

    assign sample_hs  = s_axis.tvalid && s_ready_reg;
    assign out_free   = !tvalid_reg || m_axis.tready;
    // Window size is captured on the first sample, so mid-window changes wait a window.
    assign n_eff      = (count_reg == '0) ? clamp_log2(log2_avg, MAX_LOG2_AVG) : n_reg;
    assign win_max    = (CW'(1) << n_eff) - CW'(1);
    assign sample_ext = acc_t'($signed(s_axis.tdata[SAMPLE_WIDTH-1:0]));
    assign sum        = acc_reg + sample_ext;
`ifdef AXIS_ADC_AVG_ROUND_EN
    assign result_pre = sum + ((n_eff == 4'd0) ? acc_t'(0) : (acc_t'(1) << (n_eff - 4'd1)));
`else
    assign result_pre = sum;
`endif
    assign avg        = SAMPLE_WIDTH'(result_pre >>> n_eff);

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        count_next  = count_reg;
        n_next      = n_reg;
        hold_next   = hold_reg;
        out_load    = 1'b0;
        load_sample = avg;
        unique case (state_reg)
            IDLE: begin
                if (en) state_next = ACCUM;
            end
            ACCUM: begin
                if (sample_hs) begin
                    n_next = n_eff;
                    if (count_reg == win_max) begin
                        acc_next   = '0;
                        count_next = '0;
                        if (out_free) begin
                            out_load = 1'b1;
                        end else begin
                            hold_next  = avg;
                            state_next = HOLD;
                        end
                    end else begin
                        acc_next   = sum;
                        count_next = count_reg + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (tvalid_reg && m_axis.tready) begin
                    out_load    = 1'b1;
                    load_sample = hold_reg;
                    state_next  = ACCUM;
                end
            end
            default: state_next = IDLE;
        endcase
        // Disabling drops any partial window and any held result.
        if (!en) begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
            out_load   = 1'b0;
        end
    end

    assign load_data[SAMPLE_WIDTH-1:0] = load_sample;
    genvar gi;
    generate
        for (gi = SAMPLE_WIDTH; gi < DATA_WIDTH; gi++) begin : g_sext
            assign load_data[gi] = load_sample[SAMPLE_WIDTH-1];
        end
    endgenerate

    axis_adc_avg_framer u_framer (
        .aclk       (aclk),
        .areset     (areset),
        .en         (en),
        .beat       (out_load),
        .packet_len (packet_len),
        .tlast      (frame_last)
    );

    always_ff @(posedge aclk) begin
        if (areset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_reg     <= '0;
            count_reg   <= '0;
            n_reg       <= '0;
            hold_reg    <= '0;
            s_ready_reg <= 1'b0;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
        end else begin
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            n_reg       <= n_next;
            hold_reg    <= hold_next;
            // Registered ready: low for one cycle out of reset and whenever a result is held.
            s_ready_reg <= (state_next != HOLD);
            if (out_load) begin
                tdata_reg  <= load_data;
                tvalid_reg <= 1'b1;
                tlast_reg  <= frame_last;
            end else if (m_axis.tready) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
            end
        end
    end

    assign s_axis.tready = s_ready_reg;
    assign m_axis.tdata  = tdata_reg;
    assign m_axis.tvalid = tvalid_reg;
    assign m_axis.tlast  = tlast_reg;
endmodule

// File: tb/tb_axis_adc_avg.sv
// Scoreboard bench for axis_adc_avg: expected beats are queued as windows are sent
// and matched against beats observed at the output handshake.
module tb_axis_adc_avg;
    logic        clk = 1'b0;
    logic        areset;
    logic        en;
    logic [3:0]  log2_avg;
    logic [15:0] packet_len;

    axis_adc_avg_if #(.DW(32)) s_if ();
    axis_adc_avg_if #(.DW(32)) m_if ();

    axis_adc_avg dut (
        .aclk       (clk),
        .areset     (areset),
        .en         (en),
        .log2_avg   (log2_avg),
        .packet_len (packet_len),
        .s_axis     (s_if),
        .m_axis     (m_if)
    );

    int          total = 0;
    int          bad = 0;
    int          timeouts = 0;
    int          beat_pos = 0;
    int          plen_model = 0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!areset && m_if.tvalid && m_if.tready)
            obs_q.push_back({m_if.tlast, m_if.tdata});
    end

    function automatic logic [31:0] avg_model(input longint sum, input int n);
        longint s;
        s = sum;
`ifdef AXIS_ADC_AVG_ROUND_EN
        if (n > 0) s = s + (longint'(1) << (n - 1));
`endif
        return 32'(s >>> n);
    endfunction

    task automatic push_exp(input logic [31:0] d);
        logic l;
        beat_pos++;
        l = (plen_model != 0) && ((beat_pos % plen_model) == 0);
        exp_q.push_back({l, d});
    endtask

    task automatic send(input logic [31:0] v);
        int t;
        t = 0;
        s_if.tdata  = v;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (s_if.tready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeouts++;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_window(input int vals[$], input int n);
        longint sum;
        logic [31:0] v;
        sum = 0;
        foreach (vals[i]) begin
            v = vals[i];
            sum += longint'($signed(v[23:0]));
            send(v);
        end
        push_exp(avg_model(sum, n));
    endtask

    task automatic wait_beats(input int limit);
        int t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < limit) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        areset = 1'b1; en = 1'b0; log2_avg = 4'd0; packet_len = 16'd0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
        repeat (3) @(posedge clk); #1;
        areset = 1'b0;
        exp_q.delete(); obs_q.delete(); beat_pos = 0; timeouts = 0;
    endtask

    task automatic start(input int l2, input int plen);
        log2_avg = 4'(l2); packet_len = 16'(plen); plen_model = plen; en = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; en = 1'b1; log2_avg = 4'd0; packet_len = 16'd1;
        s_if.tvalid = 1'b1; s_if.tdata = 32'd5; s_if.tlast = 1'b0; m_if.tready = 1'b1;
        repeat (2) @(posedge clk); #1;
        total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
        total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", m_if.tlast); end
        total++; if (m_if.tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h want 0", m_if.tdata); end
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", s_if.tready); end
        areset = 1'b0; en = 1'b0; s_if.tvalid = 1'b0;
        repeat (2) @(posedge clk); #1;
        total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL idle_tready: got %b want 1", s_if.tready); end
        total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL idle_tvalid: got %b want 0", m_if.tvalid); end
        $display("reset checks done");
    endtask

    task automatic test_avg_basic();
        int w[$];
        logic [32:0] o, e;
        do_reset();
        start(2, 1);
        w = {}; w.push_back(10); w.push_back(20); w.push_back(30); w.push_back(41);
        send_window(w, 2);
        w = {}; w.push_back(-100); w.push_back(50); w.push_back(7); w.push_back(8);
        send_window(w, 2);
        log2_avg = 4'd1;
        send(32'd4);
        log2_avg = 4'd2;
        send(32'd8);
        push_exp(avg_model(12, 1));
        w = {}; w.push_back(1); w.push_back(2); w.push_back(3); w.push_back(4);
        send_window(w, 2);
        wait_beats(200);
        total++; if (obs_q.size() != exp_q.size() || timeouts != 0) begin bad++; $display("FAIL basic_count: got %0d beats %0d timeouts, want %0d beats 0 timeouts", obs_q.size(), timeouts, exp_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL basic_beat: got data=%h last=%b want data=%h last=%b", o[31:0], o[32], e[31:0], e[32]); end
            else $display("basic beat data=%h last=%b", o[31:0], o[32]);
        end
    endtask

    task automatic test_round();
        int w[$];
        logic [32:0] o, e;
        do_reset();
        start(1, 0);
        w = {}; w.push_back(-3); w.push_back(-4);
        send_window(w, 1);
        w = {}; w.push_back(5); w.push_back(6);
        send_window(w, 1);
        wait_beats(100);
        total++; if (obs_q.size() != exp_q.size() || timeouts != 0) begin bad++; $display("FAIL round_count: got %0d beats %0d timeouts, want %0d beats 0 timeouts", obs_q.size(), timeouts, exp_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL round_beat: got data=%h last=%b want data=%h last=%b", o[31:0], o[32], e[31:0], e[32]); end
            else $display("round beat data=%h last=%b", o[31:0], o[32]);
        end
    endtask

    task automatic test_passthrough();
        int w[$];
        logic [32:0] o, e;
        do_reset();
        start(0, 3);
        for (int i = 1; i <= 7; i++) begin
            w = {}; w.push_back(i);
            send_window(w, 0);
            total++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'(i)) begin
                bad++; $display("FAIL pass_latency: got valid=%b data=%h want valid=1 data=%h", m_if.tvalid, m_if.tdata, 32'(i));
            end
        end
        wait_beats(100);
        total++; if (obs_q.size() != exp_q.size() || timeouts != 0) begin bad++; $display("FAIL pass_count: got %0d beats %0d timeouts, want %0d beats 0 timeouts", obs_q.size(), timeouts, exp_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL pass_beat: got data=%h last=%b want data=%h last=%b", o[31:0], o[32], e[31:0], e[32]); end
            else $display("pass beat data=%h last=%b", o[31:0], o[32]);
        end
    endtask

    task automatic test_clamp();
        int w[$];
        logic [32:0] o, e;
        do_reset();
        start(15, 2);
        w = {};
        for (int i = 0; i < 256; i++) w.push_back(i);
        send_window(w, 8);
        wait_beats(100);
        total++; if (obs_q.size() != exp_q.size() || timeouts != 0) begin bad++; $display("FAIL clamp_count: got %0d beats %0d timeouts, want %0d beats 0 timeouts", obs_q.size(), timeouts, exp_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL clamp_beat: got data=%h last=%b want data=%h last=%b", o[31:0], o[32], e[31:0], e[32]); end
            else $display("clamp beat data=%h last=%b", o[31:0], o[32]);
        end
    endtask

    task automatic test_hold();
        int w[$];
        logic [32:0] o, e;
        do_reset();
        start(1, 0);
        m_if.tready = 1'b0;
        w = {}; w.push_back(1); w.push_back(3);
        send_window(w, 1);
        w = {}; w.push_back(5); w.push_back(7);
        send_window(w, 1);
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL hold_tready: got %b want 0", s_if.tready); end
        total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd2) begin bad++; $display("FAIL hold_first: got valid=%b data=%h want valid=1 data=2", m_if.tvalid, m_if.tdata); end
        repeat (5) @(posedge clk); #1;
        total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd2 || s_if.tready !== 1'b0) begin bad++; $display("FAIL hold_stable: got valid=%b data=%h sready=%b want 1/2/0", m_if.tvalid, m_if.tdata, s_if.tready); end
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd6) begin bad++; $display("FAIL hold_release: got valid=%b data=%h want valid=1 data=6", m_if.tvalid, m_if.tdata); end
        w = {}; w.push_back(9); w.push_back(11);
        send_window(w, 1);
        wait_beats(100);
        total++; if (obs_q.size() != exp_q.size() || timeouts != 0) begin bad++; $display("FAIL hold_count: got %0d beats %0d timeouts, want %0d beats 0 timeouts", obs_q.size(), timeouts, exp_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL hold_beat: got data=%h last=%b want data=%h last=%b", o[31:0], o[32], e[31:0], e[32]); end
            else $display("hold beat data=%h last=%b", o[31:0], o[32]);
        end
    endtask

    task automatic test_saturate();
        int w[$];
        logic [32:0] o, e;
        do_reset();
        start(3, 0);
        w = {};
        for (int i = 0; i < 8; i++) w.push_back(32'h007FFFFF);
        send_window(w, 3);
        w = {};
        for (int i = 0; i < 8; i++) w.push_back(32'hAB800000);
        send_window(w, 3);
        wait_beats(100);
        total++; if (obs_q.size() != exp_q.size() || timeouts != 0) begin bad++; $display("FAIL sat_count: got %0d beats %0d timeouts, want %0d beats 0 timeouts", obs_q.size(), timeouts, exp_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL sat_beat: got data=%h last=%b want data=%h last=%b", o[31:0], o[32], e[31:0], e[32]); end
            else $display("sat beat data=%h last=%b", o[31:0], o[32]);
        end
    endtask

    task automatic test_en_abort();
        int w[$];
        logic [32:0] o, e;
        do_reset();
        start(2, 2);
        w = {}; w.push_back(8); w.push_back(8); w.push_back(8); w.push_back(8);
        send_window(w, 2);
        for (int i = 0; i < 3; i++) send(32'd999);
        en = 1'b0;
        beat_pos = 0;
        for (int i = 0; i < 4; i++) send(32'd50);
        en = 1'b1;
        repeat (2) @(posedge clk); #1;
        w = {}; w.push_back(100); w.push_back(100); w.push_back(100); w.push_back(100);
        send_window(w, 2);
        w = {}; w.push_back(-20); w.push_back(-20); w.push_back(-20); w.push_back(-20);
        send_window(w, 2);
        wait_beats(100);
        total++; if (obs_q.size() != exp_q.size() || timeouts != 0) begin bad++; $display("FAIL abort_count: got %0d beats %0d timeouts, want %0d beats 0 timeouts", obs_q.size(), timeouts, exp_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL abort_beat: got data=%h last=%b want data=%h last=%b", o[31:0], o[32], e[31:0], e[32]); end
            else $display("abort beat data=%h last=%b", o[31:0], o[32]);
        end
    endtask

    task automatic test_reset_mid();
        int w[$];
        logic [32:0] o, e;
        do_reset();
        start(2, 2);
        m_if.tready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'd5);
        areset = 1'b1;
        @(posedge clk); #1;
        total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_tvalid: got %b want 0", m_if.tvalid); end
        total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL mid_reset_tlast: got %b want 0", m_if.tlast); end
        total++; if (m_if.tdata !== 32'h0) begin bad++; $display("FAIL mid_reset_tdata: got %h want 0", m_if.tdata); end
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL mid_reset_tready: got %b want 0", s_if.tready); end
        areset = 1'b0;
        m_if.tready = 1'b1;
        beat_pos = 0;
        repeat (2) @(posedge clk); #1;
        w = {}; w.push_back(40); w.push_back(40); w.push_back(40); w.push_back(40);
        send_window(w, 2);
        w = {}; w.push_back(60); w.push_back(61); w.push_back(62); w.push_back(63);
        send_window(w, 2);
        wait_beats(100);
        total++; if (obs_q.size() != exp_q.size() || timeouts != 0) begin bad++; $display("FAIL mid_count: got %0d beats %0d timeouts, want %0d beats 0 timeouts", obs_q.size(), timeouts, exp_q.size()); end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL mid_beat: got data=%h last=%b want data=%h last=%b", o[31:0], o[32], e[31:0], e[32]); end
            else $display("mid beat data=%h last=%b", o[31:0], o[32]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_avg_basic();
        test_round();
        test_passthrough();
        test_clamp();
        test_hold();
        test_saturate();
        test_en_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
